// File: rtl/rv_dmem_arb_pkg.sv
// Shared lock-state encodings and master IDs for the data-memory arbiter.
package rv_dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_UNLOCKED = 2'd0,
    ARB_LOCK0    = 2'd1,
    ARB_LOCK1    = 2'd2
  } lock_st_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/rv_dmem_arb_if.sv
// Requester-side and memory-side buses of the data-memory arbiter.
interface rv_dmem_arb_req_if #(
  parameter int AW = 61,
  parameter int DW = 64
);
  logic            req;
  logic            we;
  logic            lock;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] strb;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (output req, we, lock, addr, wdata, strb, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, strb, output gnt, rvalid, rdata);
endinterface

interface rv_dmem_arb_mem_if #(
  parameter int AW = 61,
  parameter int DW = 64
);
  logic            en;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] strb;
  logic [DW-1:0]   rdata;

  modport master (output en, we, addr, wdata, strb, input rdata);
  modport slave  (input en, we, addr, wdata, strb, output rdata);
endinterface

// File: rtl/rv_arb_pick2.sv
// Combinational 2-way grant picker honouring the lock owner; round-robin on
// contention when RV_DMEM_ARB_RR_EN is defined, otherwise m0 always wins.
module rv_arb_pick2
  import rv_dmem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  lock_st_e   lock_st,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (lock_st)
      ARB_LOCK0: gnt[0] = req0;
      ARB_LOCK1: gnt[1] = req1;
      default: begin
        if (req0 && req1) begin
`ifdef RV_DMEM_ARB_RR_EN
          // rr_ptr holds the last winner; the other port gets this contention
          if (rr_ptr == ARB_M0) gnt[1] = 1'b1;
          else                  gnt[0] = 1'b1;
`else
          gnt[0] = 1'b1;
`endif
        end else begin
          gnt = {req1, req0};
        end
      end
    endcase
  end

`ifndef RV_DMEM_ARB_RR_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;
`endif

endmodule

// File: rtl/rv_dmem_arb.sv
// Two-port arbiter for single-ported data memory: same-cycle grant/command, response 1 cycle later.
// Requesters hold until gnt; locked port excludes the other. Optional macro: RV_DMEM_ARB_RR_EN.
module rv_dmem_arb
  import rv_dmem_arb_pkg::*;
#(
  parameter int AW = 61,
  parameter int DW = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rv_dmem_arb_req_if.slave   m0,
  rv_dmem_arb_req_if.slave   m1,
  rv_dmem_arb_mem_if.master  mem
);

  lock_st_e        lock_q, lock_d;
  logic            req0, req1;
  logic [1:0]      gnt;
  logic            acc, sel;
  logic            rr_q;
  logic            we_mux, lock_mux;
  logic [AW-1:0]   addr_mux;
  logic [DW-1:0]   wdata_mux;
  logic [DW/8-1:0] strb_mux;
  logic            rsp_valid, rsp_id, rsp_we, rsp_live;

  assign req0 = m0.req & ~rst_i;
  assign req1 = m1.req & ~rst_i;

  rv_arb_pick2 u_pick (
    .req0    (req0),
    .req1    (req1),
    .lock_st (lock_q),
    .rr_ptr  (rr_q),
    .gnt     (gnt)
  );

  assign acc = |gnt;
  assign sel = gnt[1];

`ifdef RV_DMEM_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                            rr_q <= ARB_M1;
    else if (acc && lock_q == ARB_UNLOCKED) rr_q <= sel;
  end
`else
  assign rr_q = ARB_M1;
`endif

  always_comb begin
    we_mux    = sel ? m1.we    : m0.we;
    lock_mux  = sel ? m1.lock  : m0.lock;
    addr_mux  = sel ? m1.addr  : m0.addr;
    wdata_mux = sel ? m1.wdata : m0.wdata;
    strb_mux  = sel ? m1.strb  : m0.strb;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lock_q <= ARB_UNLOCKED;
    else       lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q;
    if (acc) begin
      if (lock_mux) lock_d = sel ? ARB_LOCK1 : ARB_LOCK0;
      else          lock_d = ARB_UNLOCKED;
    end
  end

  assign m0.gnt    = gnt[0];
  assign m1.gnt    = gnt[1];
  assign mem.en    = acc;
  assign mem.we    = acc & we_mux;
  assign mem.addr  = acc ? addr_mux  : '0;
  assign mem.wdata = acc ? wdata_mux : '0;
  assign mem.strb  = (acc && we_mux) ? strb_mux : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid <= 1'b0;
      rsp_id    <= ARB_M0;
      rsp_we    <= 1'b0;
    end else begin
      rsp_valid <= acc;
      rsp_id    <= sel;
      rsp_we    <= we_mux;
    end
  end

  // A response registered just before reset must not leak out during reset
  assign rsp_live  = rsp_valid & ~rst_i;
  assign m0.rvalid = rsp_live & (rsp_id == ARB_M0);
  assign m1.rvalid = rsp_live & (rsp_id == ARB_M1);
  assign m0.rdata  = (m0.rvalid && !rsp_we) ? mem.rdata : '0;
  assign m1.rdata  = (m1.rvalid && !rsp_we) ? mem.rdata : '0;

endmodule

// File: tb/tb_rv_dmem_arb.sv
// Directed bench for rv_dmem_arb; expectations follow RV_DMEM_ARB_RR_EN when defined.
module tb_rv_dmem_arb;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rv_dmem_arb_req_if #(.AW(61), .DW(64)) m0_bus ();
  rv_dmem_arb_req_if #(.AW(61), .DW(64)) m1_bus ();
  rv_dmem_arb_mem_if #(.AW(61), .DW(64)) mem_bus ();

  rv_dmem_arb #(.AW(61), .DW(64)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input logic r, input logic w, input logic lk,
                        input logic [60:0] a, input logic [63:0] wd, input logic [7:0] st);
    m0_bus.req = r; m0_bus.we = w; m0_bus.lock = lk;
    m0_bus.addr = a; m0_bus.wdata = wd; m0_bus.strb = st;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic lk,
                        input logic [60:0] a, input logic [63:0] wd, input logic [7:0] st);
    m1_bus.req = r; m1_bus.we = w; m1_bus.lock = lk;
    m1_bus.addr = a; m1_bus.wdata = wd; m1_bus.strb = st;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    logic exp_g0;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    set_m0(1'b1, 1'b0, 1'b0, 61'h10, 64'h0, 8'hFF);
    set_m1(1'b0, 1'b0, 1'b0, 61'h0, 64'h0, 8'h00);
    mem_bus.rdata = 64'h0;

    // reset: requests are ignored and all responses are quiet
    next_cycle();
    mid();
    chk("rst_m0_gnt", m0_bus.gnt, 1'b0);
    chk("rst_mem_en", mem_bus.en, 1'b0);
    chk("rst_m0_rvalid", m0_bus.rvalid, 1'b0);
    chk("rst_m1_rdata", m1_bus.rdata, 64'h0);

    // single m0 load at 0x10 (strb given but must be masked on a read)
    next_cycle();
    rst = 1'b0;
    mid();
    chk("ld_m0_gnt", m0_bus.gnt, 1'b1);
    chk("ld_m1_gnt", m1_bus.gnt, 1'b0);
    chk("ld_mem_en", mem_bus.en, 1'b1);
    chk("ld_mem_addr", mem_bus.addr, 64'h10);
    chk("ld_mem_we", mem_bus.we, 1'b0);
    chk("ld_mem_strb", mem_bus.strb, 8'h00);
    next_cycle();
    set_m0(1'b0, 1'b0, 1'b0, 61'h0, 64'h0, 8'h00);
    mem_bus.rdata = 64'hDEADBEEF_01234567;
    mid();
    chk("ld_m0_rvalid", m0_bus.rvalid, 1'b1);
    chk("ld_m0_rdata", m0_bus.rdata, 64'hDEADBEEF_01234567);
    chk("ld_m1_rvalid", m1_bus.rvalid, 1'b0);
    chk("ld_m1_rdata", m1_bus.rdata, 64'h0);
    chk("idle_mem_en", mem_bus.en, 1'b0);
    chk("idle_mem_addr", mem_bus.addr, 64'h0);

    // single m1 store
    next_cycle();
    set_m1(1'b1, 1'b1, 1'b0, 61'h20, 64'h0000_0000_0000_CAFE, 8'h3C);
    mid();
    chk("st1_m1_gnt", m1_bus.gnt, 1'b1);
    chk("st1_mem_we", mem_bus.we, 1'b1);
    chk("st1_mem_strb", mem_bus.strb, 8'h3C);
    chk("st1_mem_wdata", mem_bus.wdata, 64'hCAFE);
    chk("st1_mem_addr", mem_bus.addr, 64'h20);
    chk("st1_m0_rvalid", m0_bus.rvalid, 1'b0);

    // contention for 4 cycles
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      set_m0(1'b1, 1'b0, 1'b0, 61'h100, 64'h0, 8'h00);
      set_m1(1'b1, 1'b0, 1'b0, 61'h200, 64'h0, 8'h00);
      mem_bus.rdata = 64'h1111_1111_1111_1111;
      mid();
`ifdef RV_DMEM_ARB_RR_EN
      exp_g0 = (i % 2 == 0);
`else
      exp_g0 = 1'b1;
`endif
      chk($sformatf("cont%0d_m0_gnt", i), m0_bus.gnt, exp_g0);
      chk($sformatf("cont%0d_m1_gnt", i), m1_bus.gnt, !exp_g0);
      if (i == 0) begin
        chk("st1_m1_rvalid", m1_bus.rvalid, 1'b1);
        chk("st1_m1_rdata", m1_bus.rdata, 64'h0);
      end
    end
    next_cycle();
    set_m0(1'b0, 1'b0, 1'b0, 61'h0, 64'h0, 8'h00);
    set_m1(1'b0, 1'b0, 1'b0, 61'h0, 64'h0, 8'h00);
    mem_bus.rdata = 64'h2222_2222_2222_2222;
    mid();
`ifdef RV_DMEM_ARB_RR_EN
    chk("cont_last_m1_rvalid", m1_bus.rvalid, 1'b1);
    chk("cont_last_m1_rdata", m1_bus.rdata, 64'h2222_2222_2222_2222);
    chk("cont_last_m0_rvalid", m0_bus.rvalid, 1'b0);
`else
    chk("cont_last_m0_rvalid", m0_bus.rvalid, 1'b1);
    chk("cont_last_m0_rdata", m0_bus.rdata, 64'h2222_2222_2222_2222);
    chk("cont_last_m1_rvalid", m1_bus.rvalid, 1'b0);
`endif

    // m1 locked store, m0 must wait until the unlocking store has gone
    next_cycle();
    set_m1(1'b1, 1'b1, 1'b1, 61'h30, 64'h0123, 8'h0F);
    mid();
    chk("lk_m1_gnt", m1_bus.gnt, 1'b1);
    chk("lk_mem_strb", mem_bus.strb, 8'h0F);
    next_cycle();
    set_m1(1'b0, 1'b0, 1'b0, 61'h0, 64'h0, 8'h00);
    set_m0(1'b1, 1'b0, 1'b0, 61'h40, 64'h0, 8'h00);
    mid();
    chk("lk_wait0_m0_gnt", m0_bus.gnt, 1'b0);
    chk("lk_wait0_mem_en", mem_bus.en, 1'b0);
    chk("lk_m1_rvalid", m1_bus.rvalid, 1'b1);
    next_cycle();
    mid();
    chk("lk_wait1_m0_gnt", m0_bus.gnt, 1'b0);
    next_cycle();
    set_m1(1'b1, 1'b1, 1'b0, 61'h30, 64'h4567, 8'hF0);
    mid();
    chk("ulk_m1_gnt", m1_bus.gnt, 1'b1);
    chk("ulk_m0_gnt", m0_bus.gnt, 1'b0);
    chk("ulk_mem_strb", mem_bus.strb, 8'hF0);
    next_cycle();
    set_m1(1'b0, 1'b0, 1'b0, 61'h0, 64'h0, 8'h00);
    mid();
    chk("ulk_after_m0_gnt", m0_bus.gnt, 1'b1);
    chk("ulk_after_mem_addr", mem_bus.addr, 64'h40);
    chk("ulk_after_m1_rvalid", m1_bus.rvalid, 1'b1);

    // back-to-back m0 load 3, store 4, load 5
    next_cycle();
    set_m0(1'b1, 1'b0, 1'b0, 61'h3, 64'h0, 8'hFF);
    mem_bus.rdata = 64'hAAAA_0000_0000_0040;
    mid();
    chk("b2b0_m0_rvalid", m0_bus.rvalid, 1'b1);
    chk("b2b0_m0_rdata", m0_bus.rdata, 64'hAAAA_0000_0000_0040);
    chk("b2b0_mem_en", mem_bus.en, 1'b1);
    chk("b2b0_mem_addr", mem_bus.addr, 64'h3);
    chk("b2b0_mem_strb", mem_bus.strb, 8'h00);
    next_cycle();
    set_m0(1'b1, 1'b1, 1'b0, 61'h4, 64'h5555_6666_7777_8888, 8'hAA);
    mem_bus.rdata = 64'hBBBB_0000_0000_0003;
    mid();
    chk("b2b1_mem_en", mem_bus.en, 1'b1);
    chk("b2b1_mem_we", mem_bus.we, 1'b1);
    chk("b2b1_mem_strb", mem_bus.strb, 8'hAA);
    chk("b2b1_mem_wdata", mem_bus.wdata, 64'h5555_6666_7777_8888);
    chk("b2b1_m0_rdata", m0_bus.rdata, 64'hBBBB_0000_0000_0003);
    next_cycle();
    set_m0(1'b1, 1'b0, 1'b0, 61'h5, 64'h9999, 8'hFF);
    mem_bus.rdata = 64'hCCCC_CCCC_CCCC_CCCC;
    mid();
    chk("b2b2_mem_en", mem_bus.en, 1'b1);
    chk("b2b2_mem_strb", mem_bus.strb, 8'h00);
    chk("b2b2_mem_wdata", mem_bus.wdata, 64'h9999);
    chk("b2b2_m0_rvalid", m0_bus.rvalid, 1'b1);
    chk("b2b2_store_rdata", m0_bus.rdata, 64'h0);
    next_cycle();
    set_m0(1'b0, 1'b0, 1'b0, 61'h0, 64'h0, 8'h00);
    mem_bus.rdata = 64'hDDDD_0000_0000_0005;
    mid();
    chk("b2b3_m0_rvalid", m0_bus.rvalid, 1'b1);
    chk("b2b3_m0_rdata", m0_bus.rdata, 64'hDDDD_0000_0000_0005);
    chk("b2b3_mem_en", mem_bus.en, 1'b0);

    // reset one cycle after an m0 load is accepted
    next_cycle();
    set_m0(1'b1, 1'b0, 1'b0, 61'h7, 64'h0, 8'h00);
    mid();
    chk("r1_m0_gnt", m0_bus.gnt, 1'b1);
    next_cycle();
    rst = 1'b1;
    mem_bus.rdata = 64'hEEEE_EEEE_EEEE_EEEE;
    mid();
    chk("r1_m0_rvalid", m0_bus.rvalid, 1'b0);
    chk("r1_m0_rdata", m0_bus.rdata, 64'h0);
    chk("r1_m0_gnt_in_rst", m0_bus.gnt, 1'b0);
    chk("r1_mem_en_in_rst", mem_bus.en, 1'b0);
    // first contention after reset goes to m0; m1 waits with a locking store
    next_cycle();
    rst = 1'b0;
    set_m1(1'b1, 1'b1, 1'b1, 61'h50, 64'h77, 8'h0F);
    mid();
    chk("r1_post_m0_gnt", m0_bus.gnt, 1'b1);
    chk("r1_post_m1_gnt", m1_bus.gnt, 1'b0);
    chk("r1_post_m0_rvalid", m0_bus.rvalid, 1'b0);
    next_cycle();
    set_m0(1'b0, 1'b0, 1'b0, 61'h0, 64'h0, 8'h00);
    mid();
    chk("r2_m1_lock_gnt", m1_bus.gnt, 1'b1);
    next_cycle();
    set_m1(1'b0, 1'b0, 1'b0, 61'h0, 64'h0, 8'h00);
    rst = 1'b1;
    mid();
    chk("r2_m1_rvalid_in_rst", m1_bus.rvalid, 1'b0);
    next_cycle();
    rst = 1'b0;
    set_m0(1'b1, 1'b0, 1'b0, 61'h9, 64'h0, 8'h00);
    mid();
    chk("r2_post_m0_gnt", m0_bus.gnt, 1'b1);
    chk("r2_post_mem_addr", mem_bus.addr, 64'h9);
    chk("r2_post_m1_rvalid", m1_bus.rvalid, 1'b0);

    next_cycle();
    set_m0(1'b0, 1'b0, 1'b0, 61'h0, 64'h0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_dmem_arb.md
Name: rv_dmem_arb

Overview:
Two-requester arbiter and sequencer for the single-ported 64-bit data memory behind the load/store byte-lane mapper.
- Port m0 is the LSU; port m1 is the debug/DMA port.
- Each port presents a word address, byte strobes and write data, already lane-mapped.
- The block grants one port per cycle, drives the memory command and routes the one-cycle-latency read data back to the requester that issued it.
- A per-port lock supports atomic read-modify-write sequences.

Parameters:
AW, 61, word-address width (byte address bits [63:3]).
DW, 64, data width; strobe width is DW/8.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
m0_req_i / m1_req_i  in  1  request valid
m0_we_i / m1_we_i  in  1  1 = store, 0 = load
m0_lock_i / m1_lock_i  in  1  hold ownership after this access
m0_addr_i / m1_addr_i  in  AW  word address
m0_wdata_i / m1_wdata_i  in  DW  store data
m0_strb_i / m1_strb_i  in  DW/8  byte strobes
m0_gnt_o / m1_gnt_o  out  1  request accepted this cycle
m0_rvalid_o / m1_rvalid_o  out  1  response for an accepted access
m0_rdata_o / m1_rdata_o  out  DW  load data
mem_en_o  out  1  memory command valid
mem_we_o  out  1  memory write enable
mem_addr_o  out  AW  memory word address
mem_wdata_o  out  DW  memory write data
mem_strb_o  out  DW/8  memory byte strobes
mem_rdata_i  in  DW  read data, valid one cycle after a read command

Behaviour:
- Handshake:
  - An access is accepted in the cycle where mX_req_i=1 and mX_gnt_o=1.
  - The requester holds req, we, lock, addr, wdata and strb stable until accepted.
  - gnt is combinational from the current-cycle requests and arbiter state.
  - At most one gnt is high per cycle. The port is fully pipelined: one accepted access per cycle.
- Memory command:
  - Issued in the same cycle as the grant: mem_en_o = granted req, and mem_we/addr/wdata/strb are muxed from the granted port.
  - mem_strb_o is forced to 0 when mem_we_o=0.
  - When nothing is granted, mem_en_o=0 and the other mem_* outputs are 0.
- Response:
  - Exactly one cycle after acceptance, the issuing port sees mX_rvalid_o=1, for both loads and stores.
  - Load: rdata = mem_rdata_i. Store: rdata = 0.
  - The non-issuing port's rdata is held at 0.
  - Tracking registers: rsp_valid, rsp_id, rsp_we.
- Lock FSM, states UNLOCKED, LOCK0, LOCK1:
  - UNLOCKED: normal arbitration.
  - An accepted access with lock_i=1 moves to LOCKn (n = winner).
  - In LOCKn only port n can be granted; the other port's req waits with gnt=0.
  - An accepted access from port n with lock_i=0 returns the FSM to UNLOCKED in the next cycle.
  - Accepted with lock_i=1 while already in LOCKn: stay in LOCKn.
- Arbitration in UNLOCKED: fixed priority, m0 over m1 (see the optional feature for round-robin).
- Simultaneous events:
  - A new grant in the same cycle as a response to the other port is allowed; the two paths are independent.
  - A single request always wins immediately unless the other port holds the lock.
- Reset (rst_i=1 at a clock edge):
  - FSM=UNLOCKED, rsp_valid=0, all rvalid_o=0, all rdata_o=0, RR pointer favours m0.
  - While rst_i is high, all gnt_o=0 and mem_en_o=0.
  - A response pending at reset is dropped, and a held lock is released.

Optional Feature:
RV_DMEM_ARB_RR_EN
- Defined: round-robin arbitration in UNLOCKED.
  - A 1-bit last-grant pointer is updated on each accept.
  - When both ports request, the port not granted last wins.
  - The pointer resets to 1, so m0 wins the first contention.
  - The pointer does not change while locked.
- Undefined: fixed priority with m0 always winning; no pointer register.

Decomposition:
- Shared include (defines.v): lock-state encodings (ARB_UNLOCKED=2'd0, ARB_LOCK0=2'd1, ARB_LOCK1=2'd2) and master IDs (ARB_M0=1'b0, ARB_M1=1'b1).
- One sub-module, rv_arb_pick2: combinational 2-way picker. Inputs are the two reqs, the lock state and the RR pointer; output is a one-hot grant.
- The FSM, response tracking and muxing stay in the top level.

Test Plan:
- m0 read addr 0x10, m1 idle; memory returns 0xDEADBEEF_01234567 next cycle → m0_gnt=1 in cycle 0, mem_en=1, mem_addr=0x10, mem_we=0; m0_rvalid=1 and m0_rdata=0xDEADBEEF_01234567 in cycle 1; m1_rvalid=0.
- Both ports request every cycle for 4 cycles, RR disabled → m0 granted all 4, m1_gnt=0. RR enabled → grants alternate m0, m1, m0, m1.
- m1 store strb=0x0F with lock=1, then m0 request, then m1 store strb=0xF0 with lock=0 → m0_gnt stays 0 until the cycle after m1's unlocking store, then m0 is granted.
- Back-to-back m0 load at addr 3, store at addr 4, load at addr 5 → three consecutive mem_en cycles; rvalid in each following cycle; the store's rdata=0; mem_strb=0 on both loads.
- rst_i asserted one cycle after an m0 read accept, and again while m1 holds the lock → m0_rvalid stays 0, the FSM returns to UNLOCKED, and after reset m0 is granted on its first request.
